alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one execute-stage ALU between two requesters: port 0 is the pipeline EX stage, port 1 is the branch/compare helper.
- Arbitrates round-robin and latches the winner's operands.
- Decodes ALUOp/Function into the 3-bit ALU control code, drives the external ALU, captures its result and returns it with a valid/ready handshake.
- Sits between the requesters and the ALU instance, replacing the direct ALU-control hookup.

Parameters:
- DATA_WIDTH, 32, width of operands and result.

Ports:
- i_Clk  input  1  system clock, rising edge
- i_Rst_n  input  1  reset, asynchronous, active-low
- i_Req0_Valid  input  1  requester 0 has an operation
- o_Req0_Ready  output  1  requester 0 operation accepted this cycle
- i_Req0_ALUOp  input  2  requester 0 ALU operation class
- i_Req0_Function  input  4  requester 0 function field
- i_Req0_A  input  DATA_WIDTH  requester 0 operand A
- i_Req0_B  input  DATA_WIDTH  requester 0 operand B
- i_Req1_Valid, o_Req1_Ready, i_Req1_ALUOp, i_Req1_Function, i_Req1_A, i_Req1_B  same as above, requester 1
- o_Rsp0_Valid  output  1  result for requester 0 available
- i_Rsp0_Ready  input  1  requester 0 consumes result
- o_Rsp1_Valid  output  1  result for requester 1 available
- i_Rsp1_Ready  input  1  requester 1 consumes result
- o_Result  output  DATA_WIDTH  held result; qualified by o_RspN_Valid
- o_Zero  output  1  held ALU zero flag
- o_ALU_Control  output  3  control code to the ALU
- o_ALU_A  output  DATA_WIDTH  ALU operand A
- o_ALU_B  output  DATA_WIDTH  ALU operand B
- i_ALU_Result  input  DATA_WIDTH  combinational ALU result
- i_ALU_Zero  input  1  combinational ALU zero flag
- o_Busy  output  1  state is not IDLE

Behaviour:
- Clock and reset: one clock i_Clk; i_Rst_n is asynchronous, active-low.
- Reset values: state IDLE; last_grant=1; all latched registers 0. Outputs reset to o_ALU_Control=000, o_ALU_A=0, o_ALU_B=0, o_Result=0, o_Zero=0, o_Rsp0/1_Valid=0, o_Busy=0. o_Req0/1_Ready are forced 0 while i_Rst_n=0.
- Decode (registered at accept):
  - ALUOp 00: Function 0000→000 (add), 0001→001 (sub), 0010→101 (and), 0011→110 (or), 0100→111 (slt), any other→000.
  - ALUOp 01→001; ALUOp 10→111; ALUOp 11→000.
- FSM states IDLE, EXEC, RESP.
- IDLE:
  - Only one valid: grant it.
  - Both valid: grant the port ≠ last_grant, so port 0 wins the first tie after reset.
  - o_ReqN_Ready=1 for the granted port only; this is combinational from the valids, in IDLE only.
  - On accept: latch A, B, decoded control and owner; last_grant←owner; go to EXEC.
  - No valid: stay in IDLE.
- EXEC (1 cycle):
  - o_ALU_A/B/Control driven from the latched registers.
  - At the clock edge, capture i_ALU_Result→o_Result and i_ALU_Zero→o_Zero; go to RESP.
- RESP:
  - o_RspOwner_Valid=1; the other response valid stays 0.
  - o_Result/o_Zero held stable until the owner's i_Rsp_Ready=1; then go to IDLE.
  - The non-owner's Rsp_Ready is ignored.
- Latency and throughput: accept at edge T, response valid at T+2. Minimum issue interval is 3 cycles; no new request is accepted in EXEC or RESP, so both Ready=0.
- ALU output drive: o_ALU_* keep the last latched values outside EXEC. The ALU sees stable inputs.
- Protocol requirements on requesters:
  - Hold Valid and payload stable until Ready.
  - A Valid dropped before grant is legal and is simply not served.
- Payload changes while Valid is high and not granted are not sampled.
- Simultaneous events: in RESP, Rsp_Ready together with a new Req_Valid → go to IDLE first; the request is granted next cycle.
- Reset mid-operation (EXEC or RESP): operation is discarded, no response is issued, last_grant returns to 1.
- Arithmetic: the block performs no arithmetic; the result width is DATA_WIDTH, passed through unchanged.

Test Plan:
1. Single request: Req0 ALUOp=00, Function=0001, A=10, B=3, Rsp0_Ready=1.
   - Ready0 pulses in cycle 0; ALU_Control=001 in EXEC.
   - Rsp0_Valid at cycle 2 with Result=7, Zero=0.
2. Tie and fairness: Req0 and Req1 both held valid continuously with ALUOp=01, Function=0000.
   - Grants alternate 0,1,0,1; each accept is 3 cycles apart.
   - Responses are routed only to the owner; ALU_Control=001.
3. Backpressure: Req1 ALUOp=00, Function=0100, A=2, B=5; Rsp1_Ready held 0 for 4 cycles.
   - Rsp1_Valid stays 1 with Result=1 stable; Ready0/Ready1=0 throughout.
   - Returns to IDLE the cycle after Rsp1_Ready=1.
4. Decode sweep: ALUOp=00 with Function 0000..0100 and 1111; then ALUOp 01, 10, 11.
   - ALU_Control = 000, 001, 101, 110, 111, 000; then 001, 111, 000.
5. Reset mid-op: assert i_Rst_n=0 during EXEC of a Req1 op.
   - All outputs return to reset values immediately; no Rsp1_Valid.
   - After release, a simultaneous Req0/Req1 tie grants port 0.
6. Zero flag: Req0 sub with A=B=0x1234.
   - o_Zero=1 and o_Result=0 at response.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Shares one external ALU between the EX stage (port 0) and the branch/compare
// helper (port 1): round-robin grant, latched operands, ALU-control decode, held result.
module alu_share_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    input  logic                  i_Req0_Valid,
    output logic                  o_Req0_Ready,
    input  logic [1:0]            i_Req0_ALUOp,
    input  logic [3:0]            i_Req0_Function,
    input  logic [DATA_WIDTH-1:0] i_Req0_A,
    input  logic [DATA_WIDTH-1:0] i_Req0_B,
    input  logic                  i_Req1_Valid,
    output logic                  o_Req1_Ready,
    input  logic [1:0]            i_Req1_ALUOp,
    input  logic [3:0]            i_Req1_Function,
    input  logic [DATA_WIDTH-1:0] i_Req1_A,
    input  logic [DATA_WIDTH-1:0] i_Req1_B,
    output logic                  o_Rsp0_Valid,
    input  logic                  i_Rsp0_Ready,
    output logic                  o_Rsp1_Valid,
    input  logic                  i_Rsp1_Ready,
    output logic [DATA_WIDTH-1:0] o_Result,
    output logic                  o_Zero,
    output logic [2:0]            o_ALU_Control,
    output logic [DATA_WIDTH-1:0] o_ALU_A,
    output logic [DATA_WIDTH-1:0] o_ALU_B,
    input  logic [DATA_WIDTH-1:0] i_ALU_Result,
    input  logic                  i_ALU_Zero,
    output logic                  o_Busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                state;
    logic                  last_grant;
    logic                  owner;
    logic                  grant;
    logic                  accept;
    logic                  rsp_take;
    logic [2:0]            ctrl_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;

    function automatic logic [2:0] decode(input logic [1:0] op, input logic [3:0] fn);
        logic [2:0] c;
        c = 3'b000;
        case (op)
            2'b00: begin
                case (fn)
                    4'b0001: c = 3'b001;
                    4'b0010: c = 3'b101;
                    4'b0011: c = 3'b110;
                    4'b0100: c = 3'b111;
                    default: c = 3'b000;
                endcase
            end
            2'b01:   c = 3'b001;
            2'b10:   c = 3'b111;
            default: c = 3'b000;
        endcase
        return c;
    endfunction

    // On a tie the port that did not win last time is served.
    always_comb begin
        grant = 1'b0;
        if (i_Req0_Valid && i_Req1_Valid) grant = ~last_grant;
        else if (i_Req1_Valid)            grant = 1'b1;
    end

    assign accept       = (state == IDLE) && (i_Req0_Valid || i_Req1_Valid);
    assign o_Req0_Ready = i_Rst_n && accept && !grant;
    assign o_Req1_Ready = i_Rst_n && accept &&  grant;
    assign rsp_take     = owner ? i_Rsp1_Ready : i_Rsp0_Ready;

    assign o_Rsp0_Valid  = (state == RESP) && !owner;
    assign o_Rsp1_Valid  = (state == RESP) &&  owner;
    assign o_Busy        = (state != IDLE);
    assign o_ALU_A       = a_q;
    assign o_ALU_B       = b_q;
    assign o_ALU_Control = ctrl_q;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            ctrl_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            o_Result   <= '0;
            o_Zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q        <= grant ? i_Req1_A : i_Req0_A;
                        b_q        <= grant ? i_Req1_B : i_Req0_B;
                        ctrl_q     <= grant ? decode(i_Req1_ALUOp, i_Req1_Function)
                                            : decode(i_Req0_ALUOp, i_Req0_Function);
                        owner      <= grant;
                        last_grant <= grant;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    o_Result <= i_ALU_Result;
                    o_Zero   <= i_ALU_Zero;
                    state    <= RESP;
                end
                RESP: begin
                    if (rsp_take) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU behind the shared port.
module tb_alu_share_arbiter;

    logic        i_Clk = 1'b0;
    logic        i_Rst_n;
    logic        i_Req0_Valid, i_Req1_Valid;
    logic        o_Req0_Ready, o_Req1_Ready;
    logic [1:0]  i_Req0_ALUOp, i_Req1_ALUOp;
    logic [3:0]  i_Req0_Function, i_Req1_Function;
    logic [31:0] i_Req0_A, i_Req0_B, i_Req1_A, i_Req1_B;
    logic        o_Rsp0_Valid, o_Rsp1_Valid;
    logic        i_Rsp0_Ready, i_Rsp1_Ready;
    logic [31:0] o_Result;
    logic        o_Zero;
    logic [2:0]  o_ALU_Control;
    logic [31:0] o_ALU_A, o_ALU_B;
    logic [31:0] i_ALU_Result;
    logic        i_ALU_Zero;
    logic        o_Busy;

    int n_chk = 0;
    int n_err = 0;

    always #5 i_Clk = ~i_Clk;

    alu_share_arbiter #(.DATA_WIDTH(32)) dut (
        .i_Clk(i_Clk), .i_Rst_n(i_Rst_n),
        .i_Req0_Valid(i_Req0_Valid), .o_Req0_Ready(o_Req0_Ready),
        .i_Req0_ALUOp(i_Req0_ALUOp), .i_Req0_Function(i_Req0_Function),
        .i_Req0_A(i_Req0_A), .i_Req0_B(i_Req0_B),
        .i_Req1_Valid(i_Req1_Valid), .o_Req1_Ready(o_Req1_Ready),
        .i_Req1_ALUOp(i_Req1_ALUOp), .i_Req1_Function(i_Req1_Function),
        .i_Req1_A(i_Req1_A), .i_Req1_B(i_Req1_B),
        .o_Rsp0_Valid(o_Rsp0_Valid), .i_Rsp0_Ready(i_Rsp0_Ready),
        .o_Rsp1_Valid(o_Rsp1_Valid), .i_Rsp1_Ready(i_Rsp1_Ready),
        .o_Result(o_Result), .o_Zero(o_Zero),
        .o_ALU_Control(o_ALU_Control), .o_ALU_A(o_ALU_A), .o_ALU_B(o_ALU_B),
        .i_ALU_Result(i_ALU_Result), .i_ALU_Zero(i_ALU_Zero),
        .o_Busy(o_Busy)
    );

    // Stand-in for the shared ALU instance.
    always_comb begin
        case (o_ALU_Control)
            3'b000:  i_ALU_Result = o_ALU_A + o_ALU_B;
            3'b001:  i_ALU_Result = o_ALU_A - o_ALU_B;
            3'b101:  i_ALU_Result = o_ALU_A & o_ALU_B;
            3'b110:  i_ALU_Result = o_ALU_A | o_ALU_B;
            3'b111:  i_ALU_Result = {31'd0, $signed(o_ALU_A) < $signed(o_ALU_B)};
            default: i_ALU_Result = 32'd0;
        endcase
        i_ALU_Zero = (i_ALU_Result == 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    // Full transaction from an IDLE cycle with response ready held high.
    task automatic run_op(input string tag, input bit port, input logic [1:0] op,
                          input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] ectl, input logic [31:0] eres, input logic ez);
        i_Rsp0_Ready = 1'b1;
        i_Rsp1_Ready = 1'b1;
        if (port) begin
            i_Req1_Valid = 1'b1; i_Req1_ALUOp = op; i_Req1_Function = fn;
            i_Req1_A = a; i_Req1_B = b;
        end else begin
            i_Req0_Valid = 1'b1; i_Req0_ALUOp = op; i_Req0_Function = fn;
            i_Req0_A = a; i_Req0_B = b;
        end
        #1;
        chk({tag, ".rdy"}, {o_Req1_Ready, o_Req0_Ready}, port ? 32'd2 : 32'd1);
        tick();
        i_Req0_Valid = 1'b0;
        i_Req1_Valid = 1'b0;
        chk({tag, ".ctl"}, o_ALU_Control, ectl);
        tick();
        chk({tag, ".rsp"}, {o_Rsp1_Valid, o_Rsp0_Valid}, port ? 32'd2 : 32'd1);
        chk({tag, ".res"}, o_Result, eres);
        chk({tag, ".zero"}, o_Zero, ez);
        tick();
        chk({tag, ".idle"}, o_Busy, 1'b0);
    endtask

    initial begin
        i_Rst_n = 1'b0;
        i_Req0_Valid = 0; i_Req0_ALUOp = 0; i_Req0_Function = 0; i_Req0_A = 0; i_Req0_B = 0;
        i_Req1_Valid = 0; i_Req1_ALUOp = 0; i_Req1_Function = 0; i_Req1_A = 0; i_Req1_B = 0;
        i_Rsp0_Ready = 0; i_Rsp1_Ready = 0;

        // Reset state; ready stays low during reset even with a valid pending.
        tick();
        i_Req0_Valid = 1'b1;
        #1;
        chk("rst.rdy0", o_Req0_Ready, 1'b0);
        chk("rst.busy", o_Busy, 1'b0);
        chk("rst.ctl", o_ALU_Control, 3'b000);
        chk("rst.res", o_Result, 32'd0);
        chk("rst.rsp", {o_Rsp1_Valid, o_Rsp0_Valid}, 32'd0);
        i_Req0_Valid = 1'b0;
        tick();
        i_Rst_n = 1'b1;
        tick();

        // 1: single sub 10-3
        run_op("t1", 1'b0, 2'b00, 4'b0001, 32'd10, 32'd3, 3'b001, 32'd7, 1'b0);

        // 2: tie fairness after a fresh reset: grants 0,1,0,1 every 3 cycles
        i_Rst_n = 1'b0;
        #1;
        i_Rst_n = 1'b1;
        tick();
        i_Rsp0_Ready = 1'b1; i_Rsp1_Ready = 1'b1;
        i_Req0_Valid = 1'b1; i_Req0_ALUOp = 2'b01; i_Req0_Function = 4'b0000;
        i_Req0_A = 32'd20; i_Req0_B = 32'd5;
        i_Req1_Valid = 1'b1; i_Req1_ALUOp = 2'b01; i_Req1_Function = 4'b0000;
        i_Req1_A = 32'd9; i_Req1_B = 32'd4;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("t2.grant", {o_Req1_Ready, o_Req0_Ready}, (k % 2) ? 32'd2 : 32'd1);
            tick();
            chk("t2.ctl", o_ALU_Control, 3'b001);
            chk("t2.norx", {o_Req1_Ready, o_Req0_Ready}, 32'd0);
            tick();
            chk("t2.rsp", {o_Rsp1_Valid, o_Rsp0_Valid}, (k % 2) ? 32'd2 : 32'd1);
            chk("t2.res", o_Result, (k % 2) ? 32'd5 : 32'd15);
            tick();
        end
        i_Req0_Valid = 1'b0; i_Req1_Valid = 1'b0;
        tick();

        // 3: backpressure on port 1, slt 2<5; port 0 waits and is not accepted
        i_Rsp1_Ready = 1'b0;
        i_Req1_Valid = 1'b1; i_Req1_ALUOp = 2'b00; i_Req1_Function = 4'b0100;
        i_Req1_A = 32'd2; i_Req1_B = 32'd5;
        #1;
        chk("t3.rdy1", o_Req1_Ready, 1'b1);
        tick();
        i_Req1_Valid = 1'b0;
        i_Req0_Valid = 1'b1; i_Req0_ALUOp = 2'b00; i_Req0_Function = 4'b0000;
        i_Req0_A = 32'd1; i_Req0_B = 32'd1;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("t3.rsp1", o_Rsp1_Valid, 1'b1);
            chk("t3.rsp0", o_Rsp0_Valid, 1'b0);
            chk("t3.res", o_Result, 32'd1);
            chk("t3.rdy", {o_Req1_Ready, o_Req0_Ready}, 32'd0);
            if (k == 3) i_Rsp1_Ready = 1'b1;
            tick();
        end
        chk("t3.idle", o_Busy, 1'b0);
        chk("t3.rdy0", o_Req0_Ready, 1'b1);
        i_Req0_Valid = 1'b0;
        tick();
        chk("t3.drop", o_Busy, 1'b0);

        // 4: decode sweep, A=12 B=10
        run_op("d0", 1'b0, 2'b00, 4'b0000, 32'd12, 32'd10, 3'b000, 32'd22, 1'b0);
        run_op("d1", 1'b0, 2'b00, 4'b0001, 32'd12, 32'd10, 3'b001, 32'd2,  1'b0);
        run_op("d2", 1'b0, 2'b00, 4'b0010, 32'd12, 32'd10, 3'b101, 32'd8,  1'b0);
        run_op("d3", 1'b1, 2'b00, 4'b0011, 32'd12, 32'd10, 3'b110, 32'd14, 1'b0);
        run_op("d4", 1'b0, 2'b00, 4'b0100, 32'd12, 32'd10, 3'b111, 32'd0,  1'b1);
        run_op("d5", 1'b0, 2'b00, 4'b1111, 32'd12, 32'd10, 3'b000, 32'd22, 1'b0);
        run_op("d6", 1'b1, 2'b01, 4'b0010, 32'd12, 32'd10, 3'b001, 32'd2,  1'b0);
        run_op("d7", 1'b0, 2'b10, 4'b0000, 32'd12, 32'd10, 3'b111, 32'd0,  1'b1);
        run_op("d8", 1'b0, 2'b11, 4'b0001, 32'd12, 32'd10, 3'b000, 32'd22, 1'b0);

        // 5: reset during EXEC of a port-1 op
        i_Req1_Valid = 1'b1; i_Req1_ALUOp = 2'b00; i_Req1_Function = 4'b0011;
        i_Req1_A = 32'h0F0; i_Req1_B = 32'h00F;
        tick();
        chk("t5.exec", o_Busy, 1'b1);
        i_Req0_Valid = 1'b1; i_Req0_ALUOp = 2'b00; i_Req0_Function = 4'b0000;
        i_Req0_A = 32'd3; i_Req0_B = 32'd4;
        i_Rst_n = 1'b0;
        #1;
        chk("t5.busy", o_Busy, 1'b0);
        chk("t5.ctl", o_ALU_Control, 3'b000);
        chk("t5.alua", o_ALU_A, 32'd0);
        chk("t5.res", o_Result, 32'd0);
        chk("t5.rsp", {o_Rsp1_Valid, o_Rsp0_Valid}, 32'd0);
        chk("t5.rdy", {o_Req1_Ready, o_Req0_Ready}, 32'd0);
        tick();
        i_Rst_n = 1'b1;
        #1;
        chk("t5.tie", {o_Req1_Ready, o_Req0_Ready}, 32'd1);
        tick();
        i_Req0_Valid = 1'b0; i_Req1_Valid = 1'b0;
        tick();
        chk("t5.rsp0", {o_Rsp1_Valid, o_Rsp0_Valid}, 32'd1);
        chk("t5.add", o_Result, 32'd7);
        tick();

        // 6: zero flag
        run_op("t6", 1'b0, 2'b00, 4'b0001, 32'h1234, 32'h1234, 3'b001, 32'd0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
